multdiv_unit: RTL

- Iterative signed 32-bit multiply/divide unit that sits directly downstream of the processor execute stage.
- The processor issues a one-cycle ctrl_MULT or ctrl_DIV pulse with its operands, stalls, and consumes data_result/data_exception when data_resultRDY pulses.
- The processor then writes data_result to the regfile, and to $rstatus when data_exception is set.
- Shift-add multiply and restoring divide, both at one bit per cycle.

---
 rtl/multdiv_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a registered result, an exception flag and a one-cycle ready pulse.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fin_q, fin_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH-1:0]   quo;
  logic               mul_exc;

  // a_q holds the multiplicand (MULT) or divisor (DIV); hi:lo is the partial
  // product for MULT and remainder:quotient for DIV.
  always_comb begin
    start     = ctrl_MULT | ctrl_DIV;
    mag_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    prod      = {hi_q, lo_q};
    sprod     = sign_q ? (~prod + 1'b1) : prod;
    mul_exc   = !((&sprod[2*WIDTH-1:WIDTH-1]) || !(|sprod[2*WIDTH-1:WIDTH-1]));
    quo       = sign_q ? (~lo_q + 1'b1) : lo_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    sign_d   = sign_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (start) begin
      cnt_d  = '0;
      fin_d  = 1'b0;
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      hi_d   = '0;
      busy_d = 1'b1;
      if (ctrl_MULT) begin
        state_d = S_MULT;
        a_d     = mag_a;
        lo_d    = mag_b;
      end else begin
        state_d = S_DIV;
        a_d     = mag_b;
        lo_d    = mag_a;
      end
    end else begin
      case (state_q)
        S_MULT: begin
          if (fin_q) begin
            state_d  = S_DONE;
            result_d = sprod[WIDTH-1:0];
            exc_d    = mul_exc;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else begin
            hi_d  = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) fin_d = 1'b1;
          end
        end
        S_DIV: begin
          if (fin_q) begin
            state_d = S_DONE;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            if (a_q == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              result_d = quo;
              exc_d    = !sign_q && lo_q[WIDTH-1];
            end
          end else begin
            if (div_shift >= {1'b0, a_q}) begin
              hi_d = div_shift[WIDTH-1:0] - a_q;
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = div_shift[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) fin_d = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      sign_q   <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      sign_q   <= sign_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
